icache_responder: RTL and testbench

- Direct-mapped instruction cache serving the fetch stage. It accepts a fetch address and returns the instruction word together with a valid strobe.
- On a miss it refills one full line from the instruction memory port, one word per transaction, and then delivers the requested word.
- It sits between the fetch stage and the memory/bus side.
- `DATA_WIDTH` comes from the shared constants header.

---
 rtl/icache_responder.sv | 165 ++++++++++++++++
 tb/tb_icache_responder.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/icache_responder.sv
// Direct-mapped instruction cache: 1-cycle hits, miss refills a whole line one word at a time, then delivers the word.
// Define ICACHE_PERF_CNT_EN to add hit_count/miss_count outputs.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module icache_responder #(
    parameter int                     NUM_LINES  = 16,
    parameter int                     LINE_WORDS = 4,
    parameter logic [`DATA_WIDTH-1:0] RESET_DATA = 32'h00000013
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fetch_req,
    input  logic [`DATA_WIDTH-1:0] fetch_addr,
    input  logic                   fetch_abort,
    input  logic                   invalidate_all,
    output logic [`DATA_WIDTH-1:0] fetch_data,
    output logic                   fetch_valid,
    output logic                   busy,
    output logic                   mem_req,
    output logic [`DATA_WIDTH-1:0] mem_addr,
    input  logic                   mem_gnt,
    input  logic [`DATA_WIDTH-1:0] mem_rdata,
    input  logic                   mem_rvalid
`ifdef ICACHE_PERF_CNT_EN
    ,
    output logic [31:0]            hit_count,
    output logic [31:0]            miss_count
`endif
);
    localparam int DW    = `DATA_WIDTH;
    localparam int OFF_W = $clog2(LINE_WORDS);
    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int TAG_W = DW - OFF_W - IDX_W - 2;
    localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
    state_t state, state_n;

    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [DW-1:0]        data_q [NUM_LINES][LINE_WORDS];
    logic [NUM_LINES-1:0] valid_q;

    logic [DW-1:2]    req_addr;
    logic [OFF_W-1:0] k, k_inc;
    logic             abort_pend, suppress;

    logic [OFF_W-1:0] f_off, r_off;
    logic [IDX_W-1:0] f_idx, r_idx;
    logic [TAG_W-1:0] f_tag, r_tag;
    logic             hit, accept, accept_hit, accept_miss, word_wr, last_wr;
    logic             unused_addr_bits;

    assign f_off = fetch_addr[OFF_W+1:2];
    assign f_idx = fetch_addr[OFF_W+2 +: IDX_W];
    assign f_tag = fetch_addr[DW-1 -: TAG_W];
    assign r_off = req_addr[OFF_W+1:2];
    assign r_idx = req_addr[OFF_W+2 +: IDX_W];
    assign r_tag = req_addr[DW-1 -: TAG_W];
    assign unused_addr_bits = ^fetch_addr[1:0];
    assign k_inc = k + 1'b1;

    // A same-cycle invalidate wins over the lookup, so the request becomes a miss.
    assign hit         = valid_q[f_idx] && (tag_q[f_idx] == f_tag) && !invalidate_all;
    assign accept      = (state == IDLE) && fetch_req && !fetch_abort;
    assign accept_hit  = accept && hit;
    assign accept_miss = accept && !hit;
    assign word_wr     = (state == WAIT) && mem_rvalid;
    assign last_wr     = word_wr && (k == LAST_WORD);

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept_miss) state_n = REQ;
            REQ:     if (mem_gnt) state_n = WAIT;
            WAIT:    if (mem_rvalid) state_n = (k == LAST_WORD) ? RESP : REQ;
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            k           <= '0;
            req_addr    <= '0;
            abort_pend  <= 1'b0;
            suppress    <= 1'b0;
            valid_q     <= '0;
            fetch_valid <= 1'b0;
            fetch_data  <= RESET_DATA;
            busy        <= 1'b0;
            mem_req     <= 1'b0;
            mem_addr    <= '0;
        end else begin
            fetch_valid <= 1'b0;
            if (invalidate_all) valid_q <= '0;
            if (state != IDLE) begin
                if (fetch_abort)    abort_pend <= 1'b1;
                if (invalidate_all) suppress   <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (accept_hit) begin
                        fetch_valid <= 1'b1;
                        fetch_data  <= data_q[f_idx][f_off];
                    end
                    if (accept_miss) begin
                        // The line is overwritten word by word, so it stops being a valid copy now.
                        valid_q[f_idx] <= 1'b0;
                        req_addr       <= fetch_addr[DW-1:2];
                        k              <= '0;
                        busy           <= 1'b1;
                        mem_req        <= 1'b1;
                        mem_addr       <= {fetch_addr[DW-1:OFF_W+2], {OFF_W{1'b0}}, 2'b00};
                    end
                end
                REQ: if (mem_gnt) mem_req <= 1'b0;
                WAIT: begin
                    if (mem_rvalid) begin
                        if (k == LAST_WORD) begin
                            if (!suppress && !invalidate_all) valid_q[r_idx] <= 1'b1;
                        end else begin
                            k        <= k_inc;
                            mem_req  <= 1'b1;
                            mem_addr <= {req_addr[DW-1:OFF_W+2], k_inc, 2'b00};
                        end
                    end
                end
                RESP: begin
                    fetch_valid <= !(abort_pend || fetch_abort);
                    fetch_data  <= data_q[r_idx][r_off];
                    busy        <= 1'b0;
                    abort_pend  <= 1'b0;
                    suppress    <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Storage needs no reset: valid_q alone decides whether contents are used.
    always_ff @(posedge clk) begin
        if (word_wr) data_q[r_idx][k] <= mem_rdata;
        if (last_wr) tag_q[r_idx]     <= r_tag;
    end

`ifdef ICACHE_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (accept_hit)  hit_count  <= hit_count + 32'd1;
            if (accept_miss) miss_count <= miss_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_responder.sv
// Bench for icache_responder: table of fetch operations against a 2-cycle gnt-to-rvalid memory model,
// plus hand sequences for back-to-back hits and reset during refill.
module tb_icache_responder;
    localparam logic [31:0] RESET_DATA = 32'h00000013;

    logic        clk = 1'b0;
    logic        reset, fetch_req, fetch_abort, invalidate_all;
    logic [31:0] fetch_addr, fetch_data, mem_addr, mem_rdata;
    logic        fetch_valid, busy, mem_req, mem_gnt, mem_rvalid;
`ifdef ICACHE_PERF_CNT_EN
    logic [31:0] hit_count, miss_count;
`endif

    always #5 clk = ~clk;

    icache_responder dut (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_abort(fetch_abort), .invalidate_all(invalidate_all),
        .fetch_data(fetch_data), .fetch_valid(fetch_valid), .busy(busy),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
        .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
`ifdef ICACHE_PERF_CNT_EN
        , .hit_count(hit_count), .miss_count(miss_count)
`endif
    );

    typedef struct {
        bit          req;
        logic [31:0] addr;
        int          abort_at;
        int          inval_at;
        bit          exp_miss;
        bit          exp_valid;
        logic [31:0] exp_data;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    int          exp_hits = 0;
    int          exp_misses = 0;
    logic [31:0] gnt_q[$];
    int          rv_cnt = 0;
    logic [31:0] rv_addr;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return 32'h11110000 + (a >> 2) - 32'd16;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory: grants in the cycle mem_req is seen, returns data two cycles after the grant.
    initial begin
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk);
            mem_gnt = 1'b0; mem_rvalid = 1'b0;
            if (rv_cnt > 0) begin
                rv_cnt--;
                if (rv_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mdata(rv_addr);
                end
            end
            if (mem_req && rv_cnt == 0 && !mem_rvalid) begin
                mem_gnt = 1'b1;
                rv_cnt  = 2;
                rv_addr = mem_addr;
                gnt_q.push_back(mem_addr);
            end
        end
    end

    // Runs one fetch operation starting at a negedge; returns at a negedge with the DUT idle.
    task automatic apply(input vec_t v, input string nm);
        int          t = 0;
        int          nv = 0;
        int          nb = 0;
        int          lat = -1;
        logic [31:0] d = '0;
        bit          done = 0;
        gnt_q.delete();
        if (v.req && v.abort_at != 0) begin
            if (v.exp_miss) exp_misses++;
            else            exp_hits++;
        end
        while (!done) begin
            fetch_req      = v.req && (t == 0);
            fetch_addr     = v.addr;
            fetch_abort    = (t == v.abort_at);
            invalidate_all = (t == v.inval_at);
            @(negedge clk);
            t++;
            if (fetch_valid) begin nv++; d = fetch_data; lat = t; end
            if (busy) nb++;
            if (!busy) done = 1;
            if (t >= 40) begin
                checks++; errors++;
                $display("FAIL %s_timeout: busy still %b after %0d cycles", nm, busy, t);
                done = 1;
            end
        end
        fetch_req = 1'b0; fetch_abort = 1'b0; invalidate_all = 1'b0;
        check({nm, "_valid_pulses"}, 32'(nv), {31'b0, v.exp_valid});
        if (v.exp_valid) begin
            check({nm, "_data"}, d, v.exp_data);
            check({nm, "_latency"}, 32'(lat), v.exp_miss ? 32'd14 : 32'd1);
        end
        check({nm, "_busy_cycles"}, 32'(nb), v.exp_miss ? 32'd13 : 32'd0);
        check({nm, "_mem_reqs"}, 32'(gnt_q.size()), v.exp_miss ? 32'd4 : 32'd0);
        for (int i = 0; i < gnt_q.size() && i < 4; i++)
            check({nm, "_mem_addr"}, gnt_q[i], (v.addr & 32'hFFFF_FFF0) + 32'(4 * i));
    endtask

    vec_t vecs[17];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int bad;
        vecs[0]  = '{1, 32'h040, -1, -1, 1, 1, 32'h11110000};  // cold miss
        vecs[1]  = '{1, 32'h04C, -1, -1, 0, 1, 32'h11110003};
        vecs[2]  = '{1, 32'h140, -1, -1, 1, 1, 32'h11110040};  // same index, other tag
        vecs[3]  = '{1, 32'h040, -1, -1, 1, 1, 32'h11110000};  // evicted
        vecs[4]  = '{1, 32'h044,  0, -1, 0, 0, 32'h0};         // abort with req: dropped
        vecs[5]  = '{1, 32'h084,  0, -1, 0, 0, 32'h0};         // aborted miss: no refill
        vecs[6]  = '{1, 32'h084,  5, -1, 1, 0, 32'h0};         // abort in WAIT of word 1
        vecs[7]  = '{1, 32'h084, -1, -1, 0, 1, 32'h11110011};
        vecs[8]  = '{0, 32'h000, -1,  0, 0, 0, 32'h0};         // invalidate in IDLE
        vecs[9]  = '{1, 32'h084, -1, -1, 1, 1, 32'h11110011};
        vecs[10] = '{1, 32'h088, -1, -1, 0, 1, 32'h11110012};
        vecs[11] = '{1, 32'h0C0, -1,  3, 1, 1, 32'h11110020};  // invalidate during refill
        vecs[12] = '{1, 32'h0C0, -1, -1, 1, 1, 32'h11110020};
        vecs[13] = '{1, 32'h0C8, -1, -1, 0, 1, 32'h11110022};
        vecs[14] = '{1, 32'h0C4, -1,  0, 1, 1, 32'h11110021};  // invalidate with req: miss
        vecs[15] = '{1, 32'h088, -1, -1, 1, 1, 32'h11110012};
        vecs[16] = '{1, 32'h040, -1, -1, 1, 1, 32'h11110000};

        reset = 1'b1; fetch_req = 1'b0; fetch_addr = '0; fetch_abort = 1'b0; invalidate_all = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_fetch_valid", {31'b0, fetch_valid}, 32'd0);
        check("rst_fetch_data", fetch_data, RESET_DATA);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_mem_req", {31'b0, mem_req}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 17; i++) apply(vecs[i], $sformatf("vec%0d", i));

        // Back-to-back hits on the freshly filled 0x40 line.
        gnt_q.delete();
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            fetch_req = 1'b1; fetch_addr = 32'h44 + 32'(4 * i);
            @(negedge clk);
            if (mem_req) bad++;
            check($sformatf("b2b_valid%0d", i), {31'b0, fetch_valid}, 32'd1);
            check($sformatf("b2b_data%0d", i), fetch_data, 32'h11110001 + 32'(i));
        end
        fetch_req = 1'b0;
        exp_hits += 3;
        @(negedge clk);
        check("b2b_no_mem_req", 32'(bad + gnt_q.size()), 32'd0);

`ifdef ICACHE_PERF_CNT_EN
        check("perf_hits", hit_count, 32'(exp_hits));
        check("perf_misses", miss_count, 32'(exp_misses));
`endif

        // Reset while waiting for the second word of a refill.
        fetch_req = 1'b1; fetch_addr = 32'h100;
        @(negedge clk);
        fetch_req = 1'b0;
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rstwait_busy", {31'b0, busy}, 32'd0);
        check("rstwait_fetch_valid", {31'b0, fetch_valid}, 32'd0);
        check("rstwait_mem_req", {31'b0, mem_req}, 32'd0);
        check("rstwait_fetch_data", fetch_data, RESET_DATA);
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (fetch_valid || mem_req || busy) bad++;
        end
        check("rstwait_late_rvalid_ignored", 32'(bad), 32'd0);
        apply('{1, 32'h100, -1, -1, 1, 1, 32'h11110030}, "rstwait_refetch");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
